// File: rtl/comp_pkg.sv
// Shared definitions for the comparator-based sort sequencer.
package comp_pkg;

    // Width of every stored value and of the comparator operands.
    localparam int unsigned DATA_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comp_sort_ctrl_if.sv
// Load, control, status and read-back signals of the sort sequencer.
interface comp_sort_ctrl_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned CW = 8
);
    import comp_pkg::*;

    logic              clear;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              start;
    logic              busy;
    logic              done;
    logic [AW:0]       count;
    logic [CW-1:0]     swap_count;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Driver side (environment feeding the sequencer).
    modport master (
        output clear, load_valid, load_data, start, rd_addr,
        input  load_ready, busy, done, count, swap_count, rd_data
    );

    // Sequencer side.
    modport slave (
        input  clear, load_valid, load_data, start, rd_addr,
        output load_ready, busy, done, count, swap_count, rd_data
    );

endinterface

// File: rtl/comp.sv
// Unsigned magnitude comparator; exactly one of the three flags is high.
module comp
    import comp_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              isbig,
    output logic              iseq,
    output logic              issmall
);

    // Pure combinational three-way compare of a against b.
    always_comb begin
        isbig   = (a > b);
        iseq    = (a == b);
        issmall = (a < b);
    end

endmodule

// File: rtl/comp_sort_ctrl.sv
// Bubble-sort sequencer: fills a small buffer, then sorts it in place using a
// single shared comparator, one compare-and-swap step per clock.
module comp_sort_ctrl
    import comp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned CW    = 8
) (
    input logic             clk,
    input logic             rst,
    comp_sort_ctrl_if.slave bus
);

    if (AW != $clog2(DEPTH)) begin : g_bad_aw
        $error("AW must equal clog2(DEPTH)");
    end

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] TWO_C   = (AW + 1)'(2);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       count_q;
    logic [CW-1:0]     swap_count_q;
    logic [AW-1:0]     idx_q;
    logic [AW-1:0]     pass_q;
    logic              swapped_q;

    logic [AW-1:0]     idx_nxt;
    logic [AW:0]       last_idx;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              isbig, iseq, issmall;
    logic              do_swap;
    logic              pass_end;
    logic              last_pass;
    logic              load_fire;

    comp u_comp (
        .a       (cmp_a),
        .b       (cmp_b),
        .isbig   (isbig),
        .iseq    (iseq),
        .issmall (issmall)
    );

    // The comparator must always give exactly one verdict.
    assert property (@(posedge clk) disable iff (rst) $onehot({isbig, iseq, issmall}));

    // Comparator operands, pass bookkeeping and handshake outputs.
    always_comb begin
        idx_nxt   = idx_q + 1'b1;
        last_idx  = count_q - TWO_C;
        cmp_a     = mem[idx_q];
        cmp_b     = mem[idx_nxt];
        // Only isbig swaps, so equal values keep their order.
        do_swap   = (state_q == SORT) && isbig;
        pass_end  = ({1'b0, idx_q} == last_idx);
        last_pass = ({1'b0, pass_q} == last_idx);

        bus.load_ready = (state_q == IDLE) && !bus.clear && !bus.start && (count_q < DEPTH_C);
        load_fire      = bus.load_valid && bus.load_ready;
        bus.busy       = (state_q == SORT);
        bus.done       = (state_q == DONE);
        bus.count      = count_q;
        bus.swap_count = swap_count_q;
        bus.rd_data    = ({1'b0, bus.rd_addr} < DEPTH_C) ? mem[bus.rd_addr] : '0;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.clear && bus.start) begin
                    state_d = (count_q >= TWO_C) ? SORT : DONE;
                end
            end
            SORT: begin
                // A pass with no swap (including this step) means sorted.
                if (pass_end && (!(swapped_q || do_swap) || last_pass)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer, counters and sort indices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            count_q      <= '0;
            swap_count_q <= '0;
            idx_q        <= '0;
            pass_q       <= '0;
            swapped_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        count_q <= '0;
                    end else if (bus.start) begin
                        swap_count_q <= '0;
                        idx_q        <= '0;
                        pass_q       <= '0;
                        swapped_q    <= 1'b0;
                    end else if (load_fire) begin
                        mem[count_q[AW-1:0]] <= bus.load_data;
                        count_q              <= count_q + 1'b1;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        mem[idx_q]   <= cmp_b;
                        mem[idx_nxt] <= cmp_a;
                        swapped_q    <= 1'b1;
                        if (swap_count_q != '1) begin
                            swap_count_q <= swap_count_q + 1'b1;
                        end
                    end
                    if (pass_end) begin
                        idx_q     <= '0;
                        pass_q    <= pass_q + 1'b1;
                        swapped_q <= 1'b0;
                    end else begin
                        idx_q <= idx_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_sort_ctrl.sv
// Randomised scoreboard bench for comp_sort_ctrl (DEPTH=4).
module tb_comp_sort_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        int cycles;
        int swaps;
    } exp_t;

    logic clk;
    logic rst;
    comp_sort_ctrl_if #(.AW(2), .CW(8)) bus ();

    comp_sort_ctrl #(.DEPTH(DEPTH), .AW(2), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   errors;
    int   checks;
    int   model_q[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   busy_cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: bubble sort with early exit. Swaps equal the inversion count;
    // passes needed = largest count of larger predecessors, plus one clean
    // pass, capped at n-1 passes of n-1 steps each.
    function automatic exp_t predict();
        exp_t e;
        int   n;
        int   inv;
        int   kmax;
        n    = model_q.size();
        inv  = 0;
        kmax = 0;
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            for (int j = 0; j < i; j++) begin
                if (model_q[j] > model_q[i]) k++;
            end
            inv += k;
            if (k > kmax) kmax = k;
        end
        if (n < 2) e.cycles = 0;
        else e.cycles = ((kmax + 1 < n - 1) ? kmax + 1 : n - 1) * (n - 1);
        e.swaps = (inv > 255) ? 255 : inv;
        return e;
    endfunction

    task automatic load_one(input int v);
        bit exp_ready;
        exp_ready      = (model_q.size() < DEPTH);
        bus.load_valid = 1'b1;
        bus.load_data  = 4'(v);
        @(negedge clk);
        check("load_ready", int'(bus.load_ready), int'(exp_ready));
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        if (exp_ready) model_q.push_back(v);
    endtask

    task automatic check_contents();
        check("count", int'(bus.count), model_q.size());
        for (int k = 0; k < model_q.size(); k++) begin
            bus.rd_addr = 2'(k);
            #1;
            check($sformatf("rd[%0d]", k), int'(bus.rd_data), model_q[k]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        model_q.delete();
        check("count_after_clear", int'(bus.count), 0);
    endtask

    task automatic run_sort();
        bit got;
        sb_q.push_back(predict());
        model_q.sort();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", int'(got), 1);
        check_contents();
    endtask

    // Monitor: counts SORT cycles and scores each done pulse.
    initial begin
        busy_cycles = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cycles = 0;
            end else begin
                if (bus.busy) busy_cycles++;
                if (bus.done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("sort_cycles", busy_cycles, mon_e.cycles);
                        check("swap_count", int'(bus.swap_count), mon_e.swaps);
                    end
                    busy_cycles = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.clear      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        bus.rd_addr    = '0;
        #12;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_count", int'(bus.count), 0);
        check("rst_swap_count", int'(bus.swap_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", int'(bus.load_ready), 1);

        // Mixed order: 3 passes, 4 swaps.
        load_one(9); load_one(3); load_one(12); load_one(1);
        run_sort();
        // Re-sort of sorted data costs a single pass.
        run_sort();

        do_clear();
        load_one(1); load_one(2); load_one(3); load_one(4);
        run_sort();

        do_clear();
        load_one(5); load_one(5); load_one(5); load_one(5);
        run_sort();

        do_clear();
        load_one(8); load_one(2);
        run_sort();

        do_clear();
        run_sort();

        // Overfill then clear+start together.
        load_one(7); load_one(6); load_one(5); load_one(4);
        load_one(15);
        check_contents();
        bus.clear = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        bus.start = 1'b0;
        model_q.delete();
        check("count_clear_start", int'(bus.count), 0);
        @(negedge clk);
        check("busy_clear_start", int'(bus.busy), 0);
        check("done_clear_start", int'(bus.done), 0);
        @(posedge clk);
        #1;

        // Randomised fills and sorts.
        for (int t = 0; t < 30; t++) begin
            int n;
            do_clear();
            n = $urandom_range(0, DEPTH);
            for (int k = 0; k < n; k++) load_one($urandom_range(0, 7));
            run_sort();
            if ($urandom_range(0, 2) == 0) run_sort();
        end

        // Reset in the second pass of a worst-case sort.
        do_clear();
        load_one(4); load_one(3); load_one(2); load_one(1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_rst", int'(bus.busy), 1);
        check("swaps_before_rst", int'(bus.swap_count), 3);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_count", int'(bus.count), 0);
        check("midrst_swap_count", int'(bus.swap_count), 0);
        for (int k = 0; k < DEPTH; k++) begin
            bus.rd_addr = 2'(k);
            #1;
            check($sformatf("midrst_mem[%0d]", k), int'(bus.rd_data), 0);
        end
        model_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_midrst", int'(bus.load_ready), 1);
        check("idle_after_midrst", int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
